uv_rsp_route: RTL

//   Return path for a fixed-priority request arbiter: records which requester won each accepted request
//   and steers the in-order downstream responses back to that requester. Sits between the arbiter/mux

---
 rtl/uv_rsp_route_if.sv | 37 +++
 rtl/uv_rsp_route.sv | 89 ++++++++
 2 files changed

// File: rtl/uv_rsp_route_if.sv
// Request/response bundle for the response return router.
// Handshake: a transfer occurs on any rising clock edge where valid and ready are
// both high; valid never waits on ready. req_fire is the already-qualified
// downstream request handshake (valid & ready), so it carries no ready of its own.
//   req_grant  one-hot grant of the request presented downstream
//   req_fire   request accepted downstream this cycle
//   req_stall  tracking FIFO full, upstream masks all requests
//   rsp_*      downstream response channel (valid/ready, data, error)
//   mst_*      per-requester response channel (valid per requester, shared data/error)
// Modport slave is taken by the router. Modport master is taken by whatever
// drives the router: the arbiter side, the downstream port and the requesters.
interface uv_rsp_route_if #(
  parameter int WIDTH = 2,
  parameter int DW    = 32
);
  logic [WIDTH-1:0] req_grant;
  logic             req_fire;
  logic             req_stall;
  logic             rsp_vld;
  logic             rsp_rdy;
  logic [DW-1:0]    rsp_data;
  logic             rsp_err;
  logic [WIDTH-1:0] mst_vld;
  logic [WIDTH-1:0] mst_rdy;
  logic [DW-1:0]    mst_data;
  logic             mst_err;

  modport slave (
    input  req_grant, req_fire, rsp_vld, rsp_data, rsp_err, mst_rdy,
    output req_stall, rsp_rdy, mst_vld, mst_data, mst_err
  );

  modport master (
    output req_grant, req_fire, rsp_vld, rsp_data, rsp_err, mst_rdy,
    input  req_stall, rsp_rdy, mst_vld, mst_data, mst_err
  );
endinterface

// File: rtl/uv_rsp_route.sv
// Return path for a fixed-priority request arbiter. Each accepted request pushes
// the index of its winning requester into a small tracking FIFO. In-order
// downstream responses are steered to the requester at the FIFO head.
// Ports:
//   clk, rst_n  clock (rising edge) and asynchronous active-low reset
//   bus         uv_rsp_route_if.slave (grant/fire, stall, response routing)
//   outstd_cnt  number of outstanding transactions (0..DEPTH)
//   ovf_err     one-cycle pulse after a dropped push (FIFO full or zero grant)
//   orphan_err  one-cycle pulse after a response arrived with nothing outstanding
module uv_rsp_route #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uv_rsp_route_if.slave        bus,
  output logic [CW-1:0]        outstd_cnt,
  output logic                 ovf_err,
  output logic                 orphan_err
);

  logic [IW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [IW-1:0] grant_idx;
  logic [IW-1:0] head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          grant_any;

  assign full      = (outstd_cnt == CW'(DEPTH));
  assign empty     = (outstd_cnt == '0);
  assign grant_any = |bus.req_grant;
  assign head      = mem[rd_ptr];

  // Lowest set bit wins: scanning from the top down lets bit 0 overwrite last.
  always_comb begin
    grant_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (bus.req_grant[i]) grant_idx = IW'(i);
    end
  end

  // A full FIFO refuses the push even if a pop frees a slot in the same cycle,
  // keeping the push decision independent of the response channel.
  assign push = bus.req_fire & grant_any & ~full;
  assign pop  = bus.rsp_vld & bus.rsp_rdy & ~empty;

  // Stall comes from registered count only, so there is no input-to-stall path.
  assign bus.req_stall = full;

  // With nothing outstanding the response is accepted and dropped so the
  // downstream port can never lock up on a stray response.
  assign bus.mst_vld  = empty ? '0 : (WIDTH'(bus.rsp_vld) << head);
  assign bus.rsp_rdy  = empty | bus.mst_rdy[head];
  assign bus.mst_data = bus.rsp_data;
  assign bus.mst_err  = bus.rsp_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      outstd_cnt <= '0;
      ovf_err    <= 1'b0;
      orphan_err <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= grant_idx;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   outstd_cnt <= outstd_cnt + CW'(1);
        2'b01:   outstd_cnt <= outstd_cnt - CW'(1);
        default: outstd_cnt <= outstd_cnt;
      endcase
      ovf_err    <= bus.req_fire & (~grant_any | full);
      orphan_err <= bus.rsp_vld & empty;
    end
  end

endmodule
